// File: rtl/motor_sched_pkg.sv
// Shared types and constants for the motor run scheduler.
// Motor ids double as round-robin tokens.
package motor_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } motor_e;

  localparam logic [7:0] DEF_M1_RUN    = 8'h88;
  localparam logic [7:0] DEF_M2_RUN    = 8'haa;
  localparam logic [7:0] DEF_M1_CANCEL = 8'h33;
  localparam logic [7:0] DEF_M2_CANCEL = 8'h66;

endpackage

// File: rtl/motor_run_scheduler_timer.sv
// Saturating up-counter with clear, enable and a terminal
// count against a limit that may change from cycle to cycle.
module sched_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/motor_run_scheduler.sv
// Command decode, round-robin grant and run/gap sequencing
// for two motors sharing one supply.
module motor_run_scheduler
  import motor_sched_pkg::*;
#(
  parameter logic [7:0] CMD_M1_RUN     = DEF_M1_RUN,
  parameter logic [7:0] CMD_M2_RUN     = DEF_M2_RUN,
  parameter logic [7:0] CMD_M1_CANCEL  = DEF_M1_CANCEL,
  parameter logic [7:0] CMD_M2_CANCEL  = DEF_M2_CANCEL,
  parameter int         TIMEOUT_CYCLES = 49152000,
  parameter int         GAP_CYCLES     = 4096,
  parameter int         CNT_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       m1_start,
  input  logic       m1_done,
  output logic       m2_start,
  input  logic       m2_done,
  output logic       led1,
  output logic       led2,
  output logic       busy,
  output logic       timeout_err,
  output logic       bad_cmd
);

  state_e     state_q, state_d;
  motor_e     grant_q, grant_d;
  motor_e     last_q, last_d;
  logic       p1_q, p1_d;
  logic       p2_q, p2_d;
  logic       s1_q, s2_q;
  logic       led1_q, led2_q;
  logic       busy_q, terr_q, terr_d, bad_q;
  logic       run1, run2, can1, can2, bad;
  logic       gdone, gcan, to_hit, tc;
  logic       gclr1, gclr2, active;
  logic       tmr_clr, tmr_en;
  logic [CNT_W-1:0] limit;

  always_comb begin
    run1 = 1'b0;
    run2 = 1'b0;
    can1 = 1'b0;
    can2 = 1'b0;
    bad  = 1'b0;
    if (rx_done) begin
      case (rx_data)
        CMD_M1_RUN:    run1 = 1'b1;
        CMD_M2_RUN:    run2 = 1'b1;
        CMD_M1_CANCEL: can1 = 1'b1;
        CMD_M2_CANCEL: can2 = 1'b1;
        default:       bad  = 1'b1;
      endcase
    end
  end

  assign gdone = (grant_q == M1) ? m1_done : m2_done;
  assign gcan  = (grant_q == M1) ? can1 : can2;

  // One counter serves both the run watchdog and the dead time.
  assign limit = (state_q == S_RUN)
               ? CNT_W'(TIMEOUT_CYCLES - 1)
               : CNT_W'(GAP_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    to_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p1_q | p2_q) begin
          if (p1_q && p2_q)
            grant_d = (last_q == M1) ? M2 : M1;
          else
            grant_d = p1_q ? M1 : M2;
          last_d  = grant_d;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = gcan ? S_GAP : S_RUN;
      S_RUN: begin
        if (gdone) begin
          state_d = S_GAP;
        end else if (tc) begin
          to_hit  = 1'b1;
          state_d = S_GAP;
        end else if (gcan) begin
          state_d = S_GAP;
        end
      end
      S_GAP: if (tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign gclr1 = (state_q == S_IDLE) &&
                 (state_d == S_GRANT) &&
                 (grant_d == M1);
  assign gclr2 = (state_q == S_IDLE) &&
                 (state_d == S_GRANT) &&
                 (grant_d == M2);

  // A RUN byte wins over the grant clearing the same flag.
  assign p1_d = (p1_q & ~gclr1 & ~can1) | run1;
  assign p2_d = (p2_q & ~gclr2 & ~can2) | run2;

  assign terr_d = (terr_q & ~(run1 | run2)) | to_hit;

  assign active = (state_q == S_GRANT) ||
                  (state_q == S_RUN);

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == S_RUN) ||
                   (state_q == S_GAP);

  sched_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= M1;
      last_q  <= M2;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      led1_q  <= 1'b0;
      led2_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_q    <= (state_d == S_RUN) && (grant_d == M1);
      s2_q    <= (state_d == S_RUN) && (grant_d == M2);
      led1_q  <= p1_q | (active && (grant_q == M1));
      led2_q  <= p2_q | (active && (grant_q == M2));
      busy_q  <= (state_d != S_IDLE);
      terr_q  <= terr_d;
      bad_q   <= bad;
    end
  end

  assign m1_start    = s1_q;
  assign m2_start    = s2_q;
  assign led1        = led1_q;
  assign led2        = led2_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign bad_cmd     = bad_q;

  a_one_motor: assert property (
    @(posedge clk) !(m1_start && m2_start)
  );

endmodule

// File: tb/tb_motor_run_scheduler.sv
// Scoreboard bench: a transaction-level model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_motor_run_scheduler;

  localparam int TO  = 100;
  localparam int GAP = 8;
  localparam int W   = 8;
  localparam logic [7:0] B_R1 = 8'h88;
  localparam logic [7:0] B_R2 = 8'haa;
  localparam logic [7:0] B_C1 = 8'h33;
  localparam logic [7:0] B_C2 = 8'h66;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       m1_done = 1'b0;
  logic       m2_done = 1'b0;
  logic       m1_start, m2_start;
  logic       led1, led2, busy;
  logic       timeout_err, bad_cmd;

  typedef struct packed {
    logic s1;
    logic s2;
    logic l1;
    logic l2;
    logic busy;
    logic terr;
    logic bad;
  } vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_n = 0;

  // model: who owns the supply (-1 none), phase flags, counts
  int   m_cur = -1;
  int   m_age = 0;
  int   m_gap = 0;
  int   m_last = 1;
  bit   m_arm = 0;
  bit   m_run = 0;
  bit   m_err = 0;
  bit   m_pend[2];

  always #5 clk = ~clk;

  motor_run_scheduler #(
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP),
    .CNT_W          (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .m1_start    (m1_start),
    .m1_done     (m1_done),
    .m2_start    (m2_start),
    .m2_done     (m2_done),
    .led1        (led1),
    .led2        (led2),
    .busy        (busy),
    .timeout_err (timeout_err),
    .bad_cmd     (bad_cmd)
  );

  task automatic model_step(
    input bit rst_n, input bit rd, input logic [7:0] b,
    input bit d1, input bit d2, output vec_t o);
    bit run_b[2];
    bit can_b[2];
    bit dn[2];
    bit grt[2];
    bit pend_old[2];
    bit bad_b, to_ev, act_old;
    int cur_old;
    o = '0;
    if (!rst_n) begin
      m_cur = -1; m_age = 0; m_gap = 0; m_last = 1;
      m_arm = 0; m_run = 0; m_err = 0;
      m_pend[0] = 0; m_pend[1] = 0;
      return;
    end
    run_b[0] = rd && (b == B_R1);
    run_b[1] = rd && (b == B_R2);
    can_b[0] = rd && (b == B_C1);
    can_b[1] = rd && (b == B_C2);
    bad_b = rd && !(run_b[0] || run_b[1] ||
                    can_b[0] || can_b[1]);
    dn[0] = d1; dn[1] = d2;
    grt[0] = 0; grt[1] = 0;
    pend_old = m_pend;
    cur_old = m_cur;
    act_old = m_arm || m_run;
    to_ev = 0;
    if (m_cur < 0) begin
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) m_cur = 1 - m_last;
        else m_cur = m_pend[0] ? 0 : 1;
        m_last = m_cur;
        grt[m_cur] = 1;
        m_arm = 1;
      end
    end else if (m_arm) begin
      m_arm = 0;
      if (can_b[m_cur]) m_gap = GAP;
      else begin m_run = 1; m_age = 0; end
    end else if (m_run) begin
      if (dn[m_cur]) begin
        m_run = 0; m_gap = GAP;
      end else if (m_age == TO - 1) begin
        m_run = 0; m_gap = GAP; to_ev = 1;
      end else if (can_b[m_cur]) begin
        m_run = 0; m_gap = GAP;
      end else begin
        m_age++;
      end
    end else begin
      m_gap--;
      if (m_gap == 0) m_cur = -1;
    end
    for (int m = 0; m < 2; m++)
      m_pend[m] = (m_pend[m] && !grt[m] && !can_b[m])
                  || run_b[m];
    m_err = (m_err && !(run_b[0] || run_b[1])) || to_ev;
    o.s1   = m_run && (m_cur == 0);
    o.s2   = m_run && (m_cur == 1);
    o.l1   = pend_old[0] || (cur_old == 0 && act_old);
    o.l2   = pend_old[1] || (cur_old == 1 && act_old);
    o.busy = (m_cur != -1);
    o.terr = m_err;
    o.bad  = bad_b;
  endtask

  task automatic cyc(input bit rst_n, input bit rd,
                     input logic [7:0] b,
                     input bit d1, input bit d2);
    vec_t e;
    reset = rst_n;
    rx_done = rd;
    rx_data = b;
    m1_done = d1;
    m2_done = d2;
    @(posedge clk);
    model_step(rst_n, rd, b, d1, d2, e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1, 1, b, 0, 0);
  endtask

  task automatic done(input int m);
    cyc(1, 0, 8'h00, m == 0, m == 1);
  endtask

  task automatic wait_run(input int m, input int n);
    int k;
    k = 0;
    while (!(m_run && m_cur == m) && k < 300) begin
      idle(1);
      k++;
    end
    if (k >= 300) begin
      miscompares++;
      $display("FAIL wait_run motor=%0d: no start in %0d cycles, need start", m + 1, k);
    end
    idle(n);
  endtask

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.s1   = m1_start;
      a.s2   = m2_start;
      a.l1   = led1;
      a.l2   = led2;
      a.busy = busy;
      a.terr = timeout_err;
      a.bad  = bad_cmd;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got s1s2l1l2 busy terr bad=%b required %b",
                 cyc_n, a, e);
      end
      vectors++;
      if (m1_start === 1'b1 && m2_start === 1'b1) begin
        miscompares++;
        $display("FAIL exclusive cyc=%0d got both starts 1, required at most one",
                 cyc_n);
      end
    end
  end

  initial begin
    int r;
    logic [7:0] rb;
    bit rd, d1, d2, rs;
    m_pend[0] = 0;
    m_pend[1] = 0;
    repeat (3) cyc(0, 1, B_R1, 0, 0);
    idle(4);
    send(B_R1);
    wait_run(0, 20);
    done(0);
    idle(12);
    send(B_R1);
    send(B_R2);
    wait_run(0, 5);
    done(0);
    wait_run(1, 5);
    done(1);
    idle(12);
    send(B_R1);
    wait_run(0, 3);
    send(B_R2);
    send(B_R1);
    idle(2);
    done(0);
    wait_run(1, 3);
    done(1);
    wait_run(0, 3);
    done(0);
    idle(12);
    send(B_R2);
    wait_run(1, 3);
    send(B_R1);
    send(B_R2);
    idle(2);
    done(1);
    wait_run(0, 2);
    done(0);
    wait_run(1, 2);
    done(1);
    idle(12);
    send(B_R1);
    idle(120);
    send(B_R1);
    wait_run(0, 4);
    done(0);
    idle(12);
    send(B_R1);
    wait_run(0, 4);
    send(B_C1);
    idle(12);
    send(B_R1);
    wait_run(0, 2);
    send(B_R2);
    send(B_C2);
    idle(3);
    done(0);
    idle(30);
    send(8'h55);
    idle(3);
    send(B_R1);
    wait_run(0, 5);
    cyc(0, 0, 8'h00, 0, 0);
    idle(5);
    for (int i = 0; i < 60000; i++) begin
      rd = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      rb = 8'($urandom());
      if (r < 2) rb = B_R1;
      else if (r < 4) rb = B_R2;
      else if (r == 4) rb = B_C1;
      else if (r == 5) rb = B_C2;
      d1 = (m_run && m_cur == 0)
         ? ($urandom_range(0, 39) == 0)
         : ($urandom_range(0, 199) == 0);
      d2 = (m_run && m_cur == 1)
         ? ($urandom_range(0, 39) == 0)
         : ($urandom_range(0, 199) == 0);
      rs = ($urandom_range(0, 2999) != 0);
      cyc(rs, rd, rb, d1, d2);
    end
    idle(20);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
